// File: rtl/siso_frame_arbiter.sv
// siso_frame_arbiter: two-requester round-robin arbiter that owns one serial
// line. The granted parallel word is shifted out MSB-first with a valid
// strobe, followed by GAP idle cycles before the next arbitration.
// Optional even-parity bit after each frame: define SISO_ARB_PARITY_EN.
`timescale 1ns/1ps

module siso_frame_arbiter #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             frame_start,
    output logic             owner,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);
    localparam logic [3:0]    GAP_LEN  = 4'(GAP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_GAP    = 2'd2
`ifdef SISO_ARB_PARITY_EN
        , S_PARITY = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             last_owner_q, last_owner_d;
    logic             sdo_q, sdo_d;
    logic             sdo_valid_q, sdo_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             owner_q, owner_d;
    logic             busy_q, busy_d;
`ifdef SISO_ARB_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             grant_sel;
    logic [WIDTH-1:0] grant_data;
    logic             end_frame;

    // Next-state and registered-output logic; every target defaulted first.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        last_owner_d  = last_owner_q;
        sdo_d         = sdo_q;
        sdo_valid_d   = sdo_valid_q;
        frame_start_d = 1'b0;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        owner_d       = owner_q;
        busy_d        = busy_q;
`ifdef SISO_ARB_PARITY_EN
        parity_d      = parity_q;
`endif
        end_frame     = 1'b0;

        // Lone requester wins; on contention the one that did not go last wins.
        grant_sel  = (req0 && req1) ? ~last_owner_q : req1;
        grant_data = grant_sel ? data1 : data0;

        case (state_q)
            S_IDLE: begin
                sdo_d       = 1'b0;
                sdo_valid_d = 1'b0;
                busy_d      = 1'b0;
                if (req0 || req1) begin
                    shreg_d       = {grant_data[WIDTH-2:0], 1'b0};
                    sdo_d         = grant_data[WIDTH-1];
                    sdo_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                    ack0_d        = ~grant_sel;
                    ack1_d        = grant_sel;
                    owner_d       = grant_sel;
                    last_owner_d  = grant_sel;
                    bit_cnt_d     = CW'(1);
                    busy_d        = 1'b1;
                    state_d       = S_SHIFT;
`ifdef SISO_ARB_PARITY_EN
                    parity_d      = ^grant_data;
`endif
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
`ifdef SISO_ARB_PARITY_EN
                    state_d = S_PARITY;
                    sdo_d   = parity_q;
`else
                    end_frame = 1'b1;
`endif
                end else begin
                    sdo_d     = shreg_q[WIDTH-1];
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
`ifdef SISO_ARB_PARITY_EN
            S_PARITY: begin
                end_frame = 1'b1;
            end
`endif
            S_GAP: begin
                if (gap_cnt_q == GAP_LEN) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    gap_cnt_d = 4'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Last serial bit has been shown: drop the line, then gap or rearbitrate.
        if (end_frame) begin
            sdo_d       = 1'b0;
            sdo_valid_d = 1'b0;
            bit_cnt_d   = '0;
            if (GAP == 0) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end else begin
                state_d   = S_GAP;
                gap_cnt_d = 4'd1;
            end
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            last_owner_q  <= 1'b1;
            sdo_q         <= 1'b0;
            sdo_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            owner_q       <= 1'b0;
            busy_q        <= 1'b0;
`ifdef SISO_ARB_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            last_owner_q  <= last_owner_d;
            sdo_q         <= sdo_d;
            sdo_valid_q   <= sdo_valid_d;
            frame_start_q <= frame_start_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            owner_q       <= owner_d;
            busy_q        <= busy_d;
`ifdef SISO_ARB_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign sdo         = sdo_q;
    assign sdo_valid   = sdo_valid_q;
    assign frame_start = frame_start_q;
    assign owner       = owner_q;
    assign busy        = busy_q;

endmodule
